// File: rtl/wb_mem_arb.sv
// wb_mem_arb: two-master (imem, dmem) to one-slave Wishbone arbiter in front
// of the QSPI memory controller. The winning request is latched on grant and
// held until the slave acknowledges; ties are round-robin or dmem-priority.
module wb_mem_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_in,
  // imem master (read-only)
  input  logic        i_stb_i,
  input  logic [31:0] i_adr_i,
  output logic        i_ack_o,
  // dmem master
  input  logic        d_stb_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  output logic        d_ack_o,
  // shared read data
  output logic [31:0] rdat_o,
  // slave side
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  typedef enum logic {
    M_I = 1'b0,
    M_D = 1'b1
  } master_e;

  state_e      state_q, state_d;
  master_e     last_q,  last_d;
  logic [31:0] adr_q,   adr_d;
  logic [31:0] dat_q,   dat_d;
  logic [3:0]  be_q,    be_d;
  logic        we_q,    we_d;
  logic        grant_i, grant_d;

  // Arbitration in IDLE, request latching on grant, release on slave ack.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    last_d  = last_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    be_d    = be_q;
    we_d    = we_q;
    grant_i = 1'b0;
    grant_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_stb_i && d_stb_i) begin
          // Tie: round-robin favours whoever did not win last time.
          grant_i = RR_EN ? (last_q == M_D) : 1'b0;
          grant_d = !grant_i;
        end else begin
          grant_i = i_stb_i;
          grant_d = d_stb_i;
        end

        if (grant_i) begin
          state_d = GNT_I;
          last_d  = M_I;
          adr_d   = i_adr_i;
          dat_d   = '0;
          be_d    = 4'hF;
          we_d    = 1'b0;
        end else if (grant_d) begin
          state_d = GNT_D;
          last_d  = M_D;
          adr_d   = d_adr_i;
          dat_d   = d_dat_i;
          be_d    = d_be_i;
          we_d    = d_we_i;
        end
      end
      // The slave cannot abort, so the grant is released only on its ack,
      // whether or not the master is still requesting.
      GNT_I, GNT_D: begin
        if (s_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers; asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (!rst_in) begin
      state_q <= IDLE;
      last_q  <= M_D;  // imem wins the first tie after reset
      adr_q   <= '0;
      dat_q   <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      be_q    <= be_d;
      we_q    <= we_d;
    end
  end

  // Slave side is driven only from the latched registers.
  assign busy_o  = (state_q != IDLE);
  assign s_stb_o = busy_o;
  assign s_adr_o = adr_q;
  assign s_dat_o = dat_q;
  assign s_be_o  = be_q;
  assign s_we_o  = we_q;

  // Zero-latency acks; a master that has dropped its stb gets no ack.
  assign i_ack_o = (state_q == GNT_I) && s_ack_i && i_stb_i;
  assign d_ack_o = (state_q == GNT_D) && s_ack_i && d_stb_i;
  assign rdat_o  = s_dat_i;

endmodule

// File: tb/tb_wb_mem_arb.sv
// Directed self-checking bench for wb_mem_arb. Instance u_rr uses round-robin
// arbitration; instance u_fp uses fixed dmem priority for the tie test.
module tb_wb_mem_arb;

  logic        clk_i = 1'b0;
  logic        rst_in = 1'b0;
  logic        i_stb_i = 1'b0;
  logic [31:0] i_adr_i = '0;
  logic        d_stb_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [3:0]  d_be_i = '0;
  logic [31:0] d_adr_i = '0;
  logic [31:0] d_dat_i = '0;
  logic        s_ack_i = 1'b0;
  logic [31:0] s_dat_i = '0;

  logic        i_ack_o, d_ack_o, s_stb_o, s_we_o, busy_o;
  logic [3:0]  s_be_o;
  logic [31:0] rdat_o, s_adr_o, s_dat_o;

  // fixed-priority instance: own request/ack lines, shared address/data
  logic        i_stb2 = 1'b0;
  logic        d_stb2 = 1'b0;
  logic        s_ack2 = 1'b0;
  logic [31:0] s_dat2 = '0;
  logic        i_ack2, d_ack2, s_stb2, s_we2, busy2;
  logic [3:0]  s_be2;
  logic [31:0] rdat2, s_adr2, s_dat_o2;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  wb_mem_arb #(.RR_EN(1'b1)) u_rr (
    .clk_i(clk_i), .rst_in(rst_in),
    .i_stb_i(i_stb_i), .i_adr_i(i_adr_i), .i_ack_o(i_ack_o),
    .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_be_i(d_be_i),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_ack_o(d_ack_o),
    .rdat_o(rdat_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .busy_o(busy_o)
  );

  wb_mem_arb #(.RR_EN(1'b0)) u_fp (
    .clk_i(clk_i), .rst_in(rst_in),
    .i_stb_i(i_stb2), .i_adr_i(i_adr_i), .i_ack_o(i_ack2),
    .d_stb_i(d_stb2), .d_we_i(d_we_i), .d_be_i(d_be_i),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_ack_o(d_ack2),
    .rdat_o(rdat2),
    .s_stb_o(s_stb2), .s_we_o(s_we2), .s_be_o(s_be2),
    .s_adr_o(s_adr2), .s_dat_o(s_dat_o2),
    .s_ack_i(s_ack2), .s_dat_i(s_dat2), .busy_o(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // watchdog: the directed sequence is short; never hang
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    #12;
    check("rst_s_stb", s_stb_o, 0);
    check("rst_busy",  busy_o, 0);
    check("rst_s_adr", s_adr_o, 0);
    check("rst_s_dat", s_dat_o, 0);
    check("rst_s_be",  s_be_o, 0);
    check("rst_s_we",  s_we_o, 0);
    check("rst_acks",  {i_ack_o, d_ack_o}, 0);
    rst_in = 1'b1;
    tick();

    // ---------------- single imem read ----------------
    i_stb_i = 1'b1;
    i_adr_i = 32'h0000_0100;
    #1;
    check("rd_no_stb_before_edge", s_stb_o, 0);
    tick();
    check("rd_s_stb",  s_stb_o, 1);
    check("rd_s_adr",  s_adr_o, 32'h0000_0100);
    check("rd_s_be",   s_be_o, 4'hF);
    check("rd_s_we",   s_we_o, 0);
    check("rd_s_dat",  s_dat_o, 0);
    tick();
    tick();
    check("rd_wait_no_ack", i_ack_o, 0);
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    #1;
    check("rd_i_ack", i_ack_o, 1);
    check("rd_rdat",  rdat_o, 32'hDEAD_BEEF);
    check("rd_d_ack", d_ack_o, 0);
    tick();
    s_ack_i = 1'b0;
    i_stb_i = 1'b0;
    #1;
    check("rd_idle_busy", busy_o, 0);
    check("rd_idle_stb",  s_stb_o, 0);

    // ---------------- stray slave ack in IDLE ----------------
    s_ack_i = 1'b1;
    #1;
    check("idle_ack_ignored", {i_ack_o, d_ack_o}, 0);
    tick();
    check("idle_ack_busy", busy_o, 0);
    s_ack_i = 1'b0;

    // ---------------- dmem write + input change during grant ----------------
    d_stb_i = 1'b1;
    d_we_i  = 1'b1;
    d_be_i  = 4'b0011;
    d_adr_i = 32'h0800_0010;
    d_dat_i = 32'h1234_5678;
    tick();
    check("wr_s_adr", s_adr_o, 32'h0800_0010);
    check("wr_s_dat", s_dat_o, 32'h1234_5678);
    check("wr_s_be",  s_be_o, 4'b0011);
    check("wr_s_we",  s_we_o, 1);
    d_adr_i = 32'hAAAA_5550;
    d_dat_i = 32'h0BAD_F00D;
    d_be_i  = 4'b1100;
    tick();
    check("hold_s_adr", s_adr_o, 32'h0800_0010);
    check("hold_s_dat", s_dat_o, 32'h1234_5678);
    check("hold_s_be",  s_be_o, 4'b0011);
    s_ack_i = 1'b1;
    #1;
    check("wr_d_ack", d_ack_o, 1);
    check("wr_i_ack", i_ack_o, 0);
    tick();
    s_ack_i = 1'b0;
    d_stb_i = 1'b0;
    #1;
    check("wr_ack_single", d_ack_o, 0);
    check("wr_idle_busy", busy_o, 0);

    // ---------------- ties: RR expects I,D,I,D; fixed expects D always ----
    d_we_i  = 1'b0;
    d_be_i  = 4'hF;
    d_adr_i = 32'h0800_0020;
    i_adr_i = 32'h0000_0200;
    i_stb_i = 1'b1;
    d_stb_i = 1'b1;
    i_stb2  = 1'b1;
    d_stb2  = 1'b1;
    for (int n = 0; n < 4; n++) begin
      logic exp_i;
      exp_i = (n % 2 == 0);
      tick();
      check($sformatf("tie%0d_rr_adr", n), s_adr_o, exp_i ? 32'h0000_0200 : 32'h0800_0020);
      check($sformatf("tie%0d_fp_adr", n), s_adr2, 32'h0800_0020);
      s_ack_i = 1'b1;
      s_ack2  = 1'b1;
      #1;
      check($sformatf("tie%0d_rr_acks", n), {i_ack_o, d_ack_o}, exp_i ? 2'b10 : 2'b01);
      check($sformatf("tie%0d_fp_acks", n), {i_ack2, d_ack2}, 2'b01);
      tick();
      s_ack_i = 1'b0;
      s_ack2  = 1'b0;
      #1;
      check($sformatf("tie%0d_rr_idle", n), busy_o, 0);
    end
    i_stb_i = 1'b0;
    d_stb_i = 1'b0;
    i_stb2  = 1'b0;
    d_stb2  = 1'b0;

    // ---------------- abort: imem drops stb mid-grant ----------------
    i_adr_i = 32'h0000_0300;
    i_stb_i = 1'b1;
    tick();
    check("ab_granted", s_stb_o, 1);
    i_stb_i = 1'b0;
    tick();
    check("ab_s_stb_held", s_stb_o, 1);
    check("ab_busy_held",  busy_o, 1);
    s_ack_i = 1'b1;
    #1;
    check("ab_acks_suppressed", {i_ack_o, d_ack_o}, 0);
    tick();
    s_ack_i = 1'b0;
    #1;
    check("ab_idle", busy_o, 0);

    // ---------------- reset during GNT_D ----------------
    d_adr_i = 32'h0800_0040;
    d_stb_i = 1'b1;
    tick();
    check("rg_busy", busy_o, 1);
    #2;
    rst_in = 1'b0;
    #1;
    check("rg_s_stb_async", s_stb_o, 0);
    check("rg_busy_async",  busy_o, 0);
    s_ack_i = 1'b1;
    #1;
    check("rg_acks", {i_ack_o, d_ack_o}, 0);
    s_ack_i = 1'b0;
    i_adr_i = 32'h0000_0400;
    i_stb_i = 1'b1;
    #2;
    rst_in = 1'b1;
    tick();
    check("rg_first_tie_imem_adr", s_adr_o, 32'h0000_0400);
    check("rg_first_tie_imem_we",  s_we_o, 0);
    s_ack_i = 1'b1;
    #1;
    check("rg_first_tie_acks", {i_ack_o, d_ack_o}, 2'b10);
    tick();
    s_ack_i = 1'b0;
    i_stb_i = 1'b0;
    d_stb_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_mem_arb.md
# wb_mem_arb

Two-master to one-slave Wishbone arbiter that shares the QSPI memory controller (`wb_qspi_mem`) between the FazyRV instruction port and the data port. It replaces the combinational imem-priority mux in the SoC top. It registers the winning request's address, write data, byte enables and write enable, then holds the grant until the slave acknowledges. Arbitration is round-robin or fixed data-priority. GPIO decode stays outside this block; only memory-bound data requests reach it.

## Interface
- `RR_EN`, default 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, dmem always wins.

- `clk_i` in 1: clock, all state on rising edge.
- `rst_in` in 1: reset, asynchronous, active-low.
- `i_stb_i` in 1: imem request (read-only).
- `i_adr_i` in 32: imem address.
- `i_ack_o` out 1: imem acknowledge.
- `d_stb_i` in 1: dmem request.
- `d_we_i` in 1: dmem write enable.
- `d_be_i` in 4: dmem byte enables.
- `d_adr_i` in 32: dmem address.
- `d_dat_i` in 32: dmem write data.
- `d_ack_o` out 1: dmem acknowledge.
- `rdat_o` out 32: read data to both masters; equals `s_dat_i`.
- `s_stb_o` out 1: slave request.
- `s_we_o` out 1: slave write enable.
- `s_be_o` out 4: slave byte enables.
- `s_adr_o` out 32: slave address.
- `s_dat_o` out 32: slave write data.
- `s_ack_i` in 1: slave acknowledge, single-cycle pulse.
- `s_dat_i` in 32: slave read data, valid with `s_ack_i`.
- `busy_o` out 1: high while a grant is held.

## Operation
- FSM states: IDLE, GNT_I, GNT_D.
- **IDLE:** sample `i_stb_i` and `d_stb_i`. With none set, stay in IDLE. With one set, grant it. With both set:
  - RR_EN=1: grant the master that is not `last_q`.
  - RR_EN=0: grant dmem.
- **On grant (IDLE edge):**
  - Latch `adr_q`, `we_q`, `be_q`, `dat_q` from the winner.
  - An imem winner latches `we_q`=0 and `be_q`=4'hF; its `dat_q` is don't-care and is latched as 0.
  - Update `last_q` to the winner.
- **GNT_x:**
  - `s_stb_o`=1; slave outputs driven from the latched registers only.
  - On `s_ack_i`, drive the granted master's ack combinationally in the same cycle, then return to IDLE at the next edge.
- **Abort:** if the granted master has dropped its stb when `s_ack_i` arrives, its ack is suppressed. The slave transaction still completes, because the QSPI controller cannot abort.
- The non-granted ack is always 0. `i_ack_o` and `d_ack_o` are never high together.
- `s_ack_i` arriving in IDLE is ignored.
- `busy_o` = (state != IDLE).
- `rdat_o` = `s_dat_i` unregistered; masters qualify it with their own ack.

## Timing
- **Reset values:**
  - state=IDLE, `last_q`=dmem (so imem wins the first tie).
  - `adr_q`, `dat_q`, `be_q`, `we_q` = 0.
  - `s_stb_o`=0, `s_we_o`=0, `s_be_o`=0, `s_adr_o`=0, `s_dat_o`=0, `busy_o`=0.
  - `i_ack_o`=0, `d_ack_o`=0.
- **Request latency:** master stb seen in IDLE at edge N; `s_stb_o` high from cycle N+1.
- **Ack latency:** zero cycles from `s_ack_i` to master ack.
- **Back-to-back:** at least one IDLE cycle between consecutive slave transactions. Minimum master-observed turnaround is 2 cycles plus slave latency.
- **Reset mid-transfer:** asynchronous return to IDLE, with `s_stb_o` deasserted immediately. The slave shares `rst_in`.
- **Stability:** latched slave outputs stay constant for the whole grant, even if master inputs change.
- **Fairness with RR_EN=1 and both masters requesting continuously:** grants strictly alternate I, D, I, D, ...

## Test plan
- **Single imem read:**
  - Stimulus: `i_stb_i`=1, `i_adr_i`=0x0000_0100; slave acks 3 cycles after `s_stb_o` with 0xDEADBEEF.
  - Response: `s_stb_o` 1 cycle after request; `s_be_o`=F, `s_we_o`=0; `i_ack_o` pulses with `rdat_o`=0xDEADBEEF; `d_ack_o` stays 0.
- **Dmem write:**
  - Stimulus: `d_adr_i`=0x0800_0010, `d_dat_i`=0x1234_5678, `d_be_i`=4'b0011, `d_we_i`=1.
  - Response: slave sees exactly those values for the whole grant; `d_ack_o` is a single pulse on `s_ack_i`.
- **Simultaneous requests, RR_EN=1, both held for 4 transactions:**
  - Response: grant order I, D, I, D.
  - Repeat with RR_EN=0: response is D on every tie.
- **Input change during grant:**
  - Stimulus: change `d_adr_i` and `d_dat_i` after grant.
  - Response: `s_adr_o` and `s_dat_o` unchanged until ack.
- **Abort:**
  - Stimulus: imem drops `i_stb_i` mid-grant.
  - Response: `s_stb_o` stays 1 until `s_ack_i`; `i_ack_o` stays 0; FSM then returns to IDLE.
- **Reset during GNT_D:**
  - Stimulus: assert `rst_in`=0 during GNT_D.
  - Response: `s_stb_o`, `busy_o` and both acks are 0 asynchronously; after release, the first tie goes to imem.
